wt_coalescing_wbuf: RTL

Parametrised write buffer for the write-through L1 data cache: accepts XLEN-wide stores from the store unit, coalesces stores to the same cache line into one line-wide entry, and issues line-wide write requests toward the L1.5/NoC adapter. It supersedes the fixed depth-8, word-granular write buffer. Line width, depth, outstanding-write limit, drain threshold and NoC byte order are all parameters.

---
 rtl/wt_coalescing_wbuf.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wt_coalescing_wbuf.sv
// wt_coalescing_wbuf: line-wide write buffer for the write-through L1 data cache.
// Stores are placed into per-line entries of a circular FIFO, age until eligible,
// and are drained one line write at a time toward the L1.5/NoC adapter.
// Optional feature macro: WBUF_COALESCE_EN (merge stores into an unlocked entry
// of the same line). Without it every store gets its own entry.
module wt_coalescing_wbuf #(
   parameter int DEPTH           = 8,
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 64,
   parameter int LINE_W          = 128,
   parameter int COALESCE_TH     = 4,
   parameter int MAX_OUTSTANDING = 7,
   parameter int BIG_ENDIAN      = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                st_valid_i,
   output logic                st_ready_o,
   input  logic [ADDR_W-1:0]   st_addr_i,
   input  logic [DATA_W-1:0]   st_data_i,
   input  logic [DATA_W/8-1:0] st_be_i,
   input  logic                flush_i,
   input  logic [ADDR_W-1:0]   chk_addr_i,
   output logic                chk_hit_o,
   output logic                mem_valid_o,
   input  logic                mem_ready_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [LINE_W-1:0]   mem_data_o,
   output logic [LINE_W/8-1:0] mem_be_o,
   input  logic                mem_ack_i,
   output logic                empty_o
);

   localparam int LINE_B = LINE_W / 8;
   localparam int DATA_B = DATA_W / 8;
   localparam int WOFF_W = $clog2(DATA_B);
   localparam int WORDS  = LINE_W / DATA_W;
   localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int AGE_W  = (COALESCE_TH > 0) ? $clog2(COALESCE_TH + 1) : 1;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_B - 1);

   // Entry storage
   logic              valid_q  [DEPTH];
   logic              valid_d  [DEPTH];
   logic              locked_q [DEPTH];
   logic              locked_d [DEPTH];
   logic [ADDR_W-1:0] addr_q   [DEPTH];
   logic [ADDR_W-1:0] addr_d   [DEPTH];
   logic [LINE_W-1:0] data_q   [DEPTH];
   logic [LINE_W-1:0] data_d   [DEPTH];
   logic [LINE_B-1:0] mask_q   [DEPTH];
   logic [LINE_B-1:0] mask_d   [DEPTH];
   logic [AGE_W-1:0]  age_q    [DEPTH];
   logic [AGE_W-1:0]  age_d    [DEPTH];

   // FIFO bookkeeping and memory-side request register
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0] mem_data_q, mem_data_d;
   logic [LINE_B-1:0] mem_be_q, mem_be_d;

   // Combinational helpers
   logic [ADDR_W-1:0] st_off;
   logic [WIDX_W-1:0] st_word;
   logic [ADDR_W-1:0] st_line;
   logic [ADDR_W-1:0] chk_line;
   logic [LINE_W-1:0] st_ldata;
   logic [LINE_B-1:0] st_lbe;
   logic [LINE_W-1:0] st_bmask;
   logic              drain_due;
   logic              issue;
   logic              pop;
   logic              hit;
   logic [PTR_W-1:0]  hit_idx;
   logic              st_fire;
   logic              alloc;
   logic              merge;
   logic              ack_ok;
   logic [LINE_W-1:0] head_data_sw;
   logic [LINE_B-1:0] head_be_sw;

   // Align the store word into its lane of the line and derive line addresses
   always_comb begin
      st_off   = st_addr_i & OFF_MASK;
      st_word  = WIDX_W'(st_off >> WOFF_W);
      st_line  = st_addr_i & ~OFF_MASK;
      chk_line = chk_addr_i & ~OFF_MASK;
      st_ldata = LINE_W'(st_data_i) << (int'(st_word) * DATA_W);
      st_lbe   = LINE_B'(st_be_i) << (int'(st_word) * DATA_B);
      st_bmask = '0;
      for (int b = 0; b < LINE_B; b++) begin
         st_bmask[b*8 +: 8] = {8{st_lbe[b]}};
      end
   end

   // Decide whether the head entry is issued this cycle and whether the pending request completes
   always_comb begin
      drain_due = (age_q[head_q] >= AGE_W'(COALESCE_TH)) || (count_q == CNT_W'(DEPTH)) || flush_i;
      issue     = valid_q[head_q] && !locked_q[head_q] && !mem_valid_q && drain_due &&
                  (out_q < OUT_W'(MAX_OUTSTANDING));
      pop       = mem_valid_q && mem_ready_i;
   end

   // Find an unlocked entry of the store's line; the head being locked this cycle is excluded
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
`ifdef WBUF_COALESCE_EN
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !locked_q[i] && (addr_q[i] == st_line) &&
             !(issue && (PTR_W'(i) == head_q))) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
`endif
   end

   // Present head data and mask in the byte order the memory side expects
   always_comb begin
      head_data_sw = '0;
      head_be_sw   = '0;
      for (int b = 0; b < LINE_B; b++) begin
         if (BIG_ENDIAN != 0) begin
            head_data_sw[b*8 +: 8] = data_q[head_q][(LINE_B-1-b)*8 +: 8];
            head_be_sw[b]          = mask_q[head_q][LINE_B-1-b];
         end else begin
            head_data_sw[b*8 +: 8] = data_q[head_q][b*8 +: 8];
            head_be_sw[b]          = mask_q[head_q][b];
         end
      end
   end

   // Next-state for entries, pointers, counters and the request register
   always_comb begin
      valid_d     = valid_q;
      locked_d    = locked_q;
      addr_d      = addr_q;
      data_d      = data_q;
      mask_d      = mask_q;
      age_d       = age_q;
      head_d      = head_q;
      tail_d      = tail_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_be_d    = mem_be_q;

      st_ready_o = hit || (count_q < CNT_W'(DEPTH));
      st_fire    = st_valid_i && st_ready_o;
      merge      = st_fire && hit;
      alloc      = st_fire && !hit;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (age_q[i] < AGE_W'(COALESCE_TH))) begin
            age_d[i] = age_q[i] + AGE_W'(1);
         end
      end

      if (merge) begin
         data_d[hit_idx] = (data_q[hit_idx] & ~st_bmask) | (st_ldata & st_bmask);
         mask_d[hit_idx] = mask_q[hit_idx] | st_lbe;
         age_d[hit_idx]  = '0;
      end

      if (alloc) begin
         valid_d[tail_q]  = 1'b1;
         locked_d[tail_q] = 1'b0;
         addr_d[tail_q]   = st_line;
         data_d[tail_q]   = st_ldata & st_bmask;
         mask_d[tail_q]   = st_lbe;
         age_d[tail_q]    = '0;
         tail_d           = tail_q + PTR_W'(1);
      end

      if (issue) begin
         locked_d[head_q] = 1'b1;
         mem_valid_d      = 1'b1;
         mem_addr_d       = addr_q[head_q];
         mem_data_d       = head_data_sw;
         mem_be_d         = head_be_sw;
      end

      if (pop) begin
         valid_d[head_q]  = 1'b0;
         locked_d[head_q] = 1'b0;
         head_d           = head_q + PTR_W'(1);
         mem_valid_d      = 1'b0;
      end

      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

      ack_ok = mem_ack_i && (out_q != '0);
      out_d  = out_q;
      if (pop && !ack_ok) begin
         out_d = out_q + OUT_W'(1);
      end else if (!pop && ack_ok) begin
         out_d = out_q - OUT_W'(1);
      end
   end

   // Load-hazard check over every buffered entry, locked or not
   always_comb begin
      chk_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == chk_line)) begin
            chk_hit_o = 1'b1;
         end
      end
   end

   // State registers; reset discards all entries and the outstanding count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            locked_q[i] <= 1'b0;
            addr_q[i]   <= '0;
            data_q[i]   <= '0;
            mask_q[i]   <= '0;
            age_q[i]    <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_be_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         age_q       <= age_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         out_q       <= out_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_be_q    <= mem_be_d;
      end
   end

   assign mem_valid_o = mem_valid_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_data_o  = mem_data_q;
   assign mem_be_o    = mem_be_q;
   assign empty_o     = (count_q == '0) && (out_q == '0);

endmodule
